// File: rtl/pulse_div_ctrl.sv
// pulse_div_ctrl: divides qualified input events by DIV_N into Z pulses, in bursts of BURST_LEN
module pulse_div_ctrl #(
   parameter int DIV_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             CLK_50M,
   input  logic             RST,
   input  logic             START,
   input  logic             STOP,
   input  logic             ACK,
   input  logic [DIV_W-1:0] DIV_N,
   input  logic [CNT_W-1:0] BURST_LEN,
   input  logic             X,
   output logic             Z,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [CNT_W-1:0] Z_CNT
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
   state_t state_q, state_d;
   logic [DIV_W-1:0] phase_q, phase_d, div_q, div_d;
   logic [CNT_W-1:0] burst_q, burst_d, z_cnt_q, z_cnt_d, z_cnt_inc;
   logic z_q, z_d, err_q, err_d;
   logic accept, hit, last;
   assign accept = (state_q == S_IDLE) && START && (DIV_N != '0);
   assign hit = (state_q == S_RUN) && X && !STOP && (phase_q == div_q - DIV_W'(1));
   assign z_cnt_inc = z_cnt_q + CNT_W'(1);
   assign last = hit && (burst_q != '0) && (z_cnt_inc == burst_q);
   // state register plus datapath flops, all cleared by synchronous reset
   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         div_q   <= '0;
         burst_q <= '0;
         z_cnt_q <= '0;
         z_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         div_q   <= div_d;
         burst_q <= burst_d;
         z_cnt_q <= z_cnt_d;
         z_q     <= z_d;
         err_q   <= err_d;
      end
   end
   // next state; STOP beats a final hit, unused encodings fall back to IDLE
   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:  state_d = accept ? S_RUN : S_IDLE;
         S_RUN:   state_d = STOP ? S_IDLE : (last ? S_DONE : S_RUN);
         S_DONE:  state_d = ACK ? S_IDLE : S_DONE;
         default: state_d = S_IDLE;
      endcase
   end
   // datapath: latch ratio/length on accept, advance phase on X, count Z events
   always_comb begin
      div_d   = accept ? DIV_N : div_q;
      burst_d = accept ? BURST_LEN : burst_q;
      phase_d = (accept || hit || (state_q == S_RUN && STOP)) ? '0 :
                (state_q == S_RUN && X) ? phase_q + DIV_W'(1) : phase_q;
      z_cnt_d = accept ? '0 : hit ? z_cnt_inc : z_cnt_q;
      z_d     = hit;
      err_d   = (state_q == S_IDLE) && START && (DIV_N == '0);
   end
   // outputs: status decoded from state, pulses and count straight from flops
   always_comb begin
      BUSY  = state_q == S_RUN;
      DONE  = state_q == S_DONE;
      Z     = z_q;
      ERR   = err_q;
      Z_CNT = z_cnt_q;
   end
endmodule

// File: tb/tb_pulse_div_ctrl.sv
// tb_pulse_div_ctrl: scoreboard bench with an event-count reference model
module tb_pulse_div_ctrl;
   logic clk, rst, start, stop, ack, x, z, busy, done, err;
   logic [3:0] divn;
   logic [7:0] blen, z_cnt;
   typedef struct packed {
      logic z, busy, done, err;
      logic [7:0] zcnt;
   } exp_t;
   exp_t exp_q[$];
   int n_cmp = 0, n_bad = 0;
   int m_mode = 0, m_div = 0, m_burst = 0, m_ev = 0, m_z = 0;

   pulse_div_ctrl #(.DIV_W(4), .CNT_W(8)) dut (
      .CLK_50M(clk), .RST(rst), .START(start), .STOP(stop), .ACK(ack),
      .DIV_N(divn), .BURST_LEN(blen), .X(x),
      .Z(z), .BUSY(busy), .DONE(done), .ERR(err), .Z_CNT(z_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference: counts X events since START; every div-th event is a Z
   task automatic model(input bit r, s, p, a, xx, input int dn, bl);
      exp_t e;
      e = '0;
      if (r) begin
         m_mode = 0; m_div = 0; m_burst = 0; m_ev = 0; m_z = 0;
      end else if (m_mode == 0) begin
         if (s) begin
            if (dn != 0) begin
               m_div = dn; m_burst = bl; m_ev = 0; m_z = 0; m_mode = 1;
            end else e.err = 1'b1;
         end
      end else if (m_mode == 1) begin
         if (p) begin
            m_mode = 0; m_ev = 0;
         end else if (xx) begin
            m_ev++;
            if (m_ev % m_div == 0) begin
               e.z = 1'b1;
               m_z++;
               if (m_burst != 0 && m_z == m_burst) m_mode = 2;
            end
         end
      end else if (a) m_mode = 0;
      e.busy = m_mode == 1;
      e.done = m_mode == 2;
      e.zcnt = 8'(m_z % 256);
      exp_q.push_back(e);
   endtask

   task automatic cyc(input bit r, s, p, a, xx, input int dn, bl);
      rst = r; start = s; stop = p; ack = a; x = xx;
      divn = 4'(dn); blen = 8'(bl);
      @(posedge clk);
      model(r, s, p, a, xx, dn, bl);
      #1;
   endtask

   // monitor: one expected record per clock edge, compared mid-cycle
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("z", z, e.z);
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
            chk("err", err, e.err);
            chk("z_cnt", z_cnt, e.zcnt);
         end
      end
   end

   initial begin
      int pat[6] = '{1, 0, 1, 0, 1, 1};
      rst = 1'b1; start = 0; stop = 0; ack = 0; x = 0; divn = 0; blen = 0;
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 3, 2);
      cyc(0, 0, 0, 0, 0, 0, 0);
      // ratio 3, burst 2
      cyc(0, 1, 0, 0, 0, 3, 2);
      repeat (6) cyc(0, 0, 0, 0, 1, 0, 0);
      chk("burst_zcnt", z_cnt, 2);
      chk("burst_done", done, 1);
      cyc(0, 1, 1, 0, 1, 5, 5);
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("ack_idle", done | busy, 0);
      // ratio 1, continuous, wraps the counter
      cyc(0, 1, 0, 1, 0, 1, 0);
      repeat (300) cyc(0, 0, 0, 0, 1, 0, 0);
      chk("wrap_zcnt", z_cnt, 44);
      chk("wrap_busy", busy, 1);
      cyc(0, 0, 1, 0, 1, 0, 0);
      chk("stop_busy", busy, 0);
      // rejected start
      cyc(0, 1, 0, 0, 0, 0, 7);
      chk("rej_err", err, 1);
      chk("rej_zcnt", z_cnt, 44);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("rej_err_clear", err, 0);
      // stop on the third X wins over the Z
      cyc(0, 1, 0, 0, 0, 3, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 1, 0, 0);
      chk("stop_no_z", z, 0);
      // reset mid-burst
      cyc(0, 1, 0, 0, 0, 2, 4);
      repeat (4) cyc(0, 0, 0, 0, 1, 0, 0);
      chk("pre_rst_zcnt", z_cnt, 2);
      cyc(1, 1, 1, 1, 1, 3, 3);
      chk("rst_zcnt", z_cnt, 0);
      repeat (4) cyc(0, 0, 0, 0, 1, 0, 0);
      // gaps in X keep the phase
      cyc(0, 1, 0, 0, 0, 2, 0);
      foreach (pat[i]) cyc(0, 0, 0, 0, pat[i] != 0, 0, 0);
      // reset pulse between edges is not seen
      rst = 1'b1; #2; rst = 1'b0;
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 5), $urandom_range(0, 6));
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      chk("drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
